// File: rtl/pipe_stage_chain_if.sv
// pipe_stage_chain_if: valid/ready/data stream bundle for the elastic pipeline chain
// Ports (modports):
//   master - drives valid and data, observes ready (producer side)
//   slave  - observes valid and data, drives ready (consumer side)
interface pipe_stage_chain_if #(
    parameter int WIDTH = 32
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;
    modport master (output valid, data, input ready);
    modport slave  (input valid, data, output ready);
endinterface

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: elastic DEPTH-stage register chain with bubble collapse, flush and occupancy count
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-low reset
//   flush - synchronous squash of every stage; masks both handshakes that cycle
//   up    - upstream stream (slave): in_valid / in_ready / in_data
//   dn    - downstream stream (master): out_valid / out_ready / out_data
//   count - registered number of valid stages, 0..DEPTH
module pipe_stage_chain #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    pipe_stage_chain_if.slave       up,
    pipe_stage_chain_if.master      dn,
    output logic [CW-1:0]           count
);
    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] v, mv;
    logic             m, in_fire, out_fire;
    // mv[k]: stage k may load, i.e. it or some stage after it is empty, or the output drains.
    // Built with a running variable so the ready chain is one pure combinational sweep.
    always_comb begin
        mv = '0;
        m  = dn.ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            m     = m | ~v[k];
            mv[k] = m;
        end
    end
    // in_ready is forced low while reset is asserted even though every stage reads empty.
    assign up.ready = mv[0] & ~flush & rst;
    assign dn.valid = v[DEPTH-1] & ~flush;
    assign dn.data  = data[DEPTH-1];
    assign in_fire  = up.valid & up.ready;
    assign out_fire = dn.valid & dn.ready;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) data[k] <= '0;
            v     <= '0;
            count <= '0;
        end else if (flush) begin
            v     <= '0;
            count <= '0;
        end else begin
            if (mv[0]) begin
                if (up.valid) data[0] <= up.data;
                v[0] <= in_fire;
            end
            // Data only moves with a valid source, so an emptied slot keeps its old payload.
            for (int k = 1; k < DEPTH; k++) begin
                if (mv[k]) begin
                    if (v[k-1]) data[k] <= data[k-1];
                    v[k] <= v[k-1];
                end
            end
            count <= count + CW'(in_fire) - CW'(out_fire);
        end
    end
endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: directed self-checking bench for pipe_stage_chain (WIDTH=8, DEPTH=3)
module tb_pipe_stage_chain;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic [1:0] count;
    logic       acc;
    logic [7:0] src[$];
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int         errors = 0;
    int         checks = 0;
    pipe_stage_chain_if #(.WIDTH(8)) up ();
    pipe_stage_chain_if #(.WIDTH(8)) dn ();
    pipe_stage_chain #(.WIDTH(8), .DEPTH(3)) dut (
        .clk(clk), .rst(rst), .flush(flush), .up(up), .dn(dn), .count(count)
    );
    always #5 clk = ~clk;
    // Words delivered downstream, sampled mid-cycle before the edge that completes the transfer.
    always @(negedge clk) if (dn.valid && dn.ready) got.push_back(dn.data);
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic check_got(input string tag);
        check({tag, "_n"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) check(tag, got[i], exp_q[i]);
        got.delete();
        exp_q.delete();
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    // Presents the head of src for n cycles, popping it whenever it was accepted.
    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            up.valid = src.size() != 0;
            up.data  = src.size() != 0 ? src[0] : 8'h00;
            #1;
            acc = up.valid & up.ready;
            cyc();
            if (acc) void'(src.pop_front());
        end
        up.valid = 1'b0;
    endtask
    initial begin
        up.valid = 1'b0;
        up.data  = 8'h00;
        dn.ready = 1'b0;
        #2;
        check("rst_out_valid", dn.valid, 0);
        check("rst_out_data", dn.data, 0);
        check("rst_count", count, 0);
        check("rst_in_ready", up.ready, 0);
        #6 rst = 1'b1;
        #1;
        check("idle_in_ready", up.ready, 1);
        // Stream: first word visible after its third edge, then one per cycle.
        dn.ready = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            up.valid = 1'b1;
            up.data  = 8'(i);
            cyc();
            check("stream_v", dn.valid, i >= 3);
            if (i >= 3) begin
                check("stream_d", dn.data, i - 2);
                check("stream_cnt", count, 3);
            end
        end
        up.valid = 1'b0;
        repeat (4) cyc();
        check("stream_cnt_end", count, 0);
        for (int i = 1; i <= 6; i++) exp_q.push_back(8'(i));
        check_got("stream_order");
        // Fill/stall: only three words fit while the output is blocked.
        src = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        dn.ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            up.valid = 1'b1;
            up.data  = src[0];
            #1;
            check("fill_rdy", up.ready, c < 3);
            acc = up.ready;
            cyc();
            if (acc) void'(src.pop_front());
        end
        up.valid = 1'b0;
        check("fill_cnt", count, 3);
        check("fill_left", src.size(), 2);
        dn.ready = 1'b1;
        run(6);
        exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        check_got("fill_order");
        // Bubble collapse while the output is stalled.
        dn.ready = 1'b0;
        up.valid = 1'b1; up.data = 8'h11;
        cyc();
        up.valid = 1'b0;
        cyc();
        cyc();
        up.valid = 1'b1; up.data = 8'h22;
        cyc();
        up.valid = 1'b0;
        cyc();
        check("bub_cnt", count, 2);
        check("bub_v", 32'(dut.v), 32'b110);
        dn.ready = 1'b1;
        cyc();
        check("bub_v2", dn.valid, 1);
        check("bub_d2", dn.data, 8'h22);
        cyc();
        check("bub_empty", dn.valid, 0);
        exp_q = '{8'h11, 8'h22};
        check_got("bub_order");
        // Full chain accepting and delivering in the same cycle.
        dn.ready = 1'b0;
        src = '{8'hB1, 8'hB2, 8'hB3};
        run(3);
        check("full_cnt", count, 3);
        up.valid = 1'b1; up.data = 8'h55; dn.ready = 1'b1;
        #1;
        check("full_rdy", up.ready, 1);
        cyc();
        up.valid = 1'b0;
        check("full_cnt_hold", count, 3);
        repeat (4) cyc();
        exp_q = '{8'hB1, 8'hB2, 8'hB3, 8'h55};
        check_got("full_order");
        // Flush wins over both handshakes and nothing stale escapes.
        dn.ready = 1'b0;
        src = '{8'hC1, 8'hC2, 8'hC3};
        run(3);
        check("fl_cnt_pre", count, 3);
        flush = 1'b1; up.valid = 1'b1; up.data = 8'h66; dn.ready = 1'b1;
        #1;
        check("fl_out_valid", dn.valid, 0);
        check("fl_in_ready", up.ready, 0);
        cyc();
        flush = 1'b0; up.valid = 1'b0;
        check("fl_cnt", count, 0);
        check("fl_v_after", dn.valid, 0);
        repeat (4) cyc();
        check_got("fl_none");
        // Asynchronous reset between edges, then normal latency.
        dn.ready = 1'b0;
        src = '{8'hD1, 8'hD2};
        run(2);
        cyc();
        check("ar_cnt_pre", count, 2);
        check("ar_v_pre", dn.valid, 1);
        check("ar_d_pre", dn.data, 8'hD1);
        #3 rst = 1'b0;
        #1;
        check("ar_out_valid", dn.valid, 0);
        check("ar_out_data", dn.data, 0);
        check("ar_count", count, 0);
        check("ar_in_ready", up.ready, 0);
        #1 rst = 1'b1;
        dn.ready = 1'b1;
        up.valid = 1'b1; up.data = 8'h7E;
        cyc();
        up.valid = 1'b0;
        check("ar_lat1", dn.valid, 0);
        cyc();
        check("ar_lat2", dn.valid, 0);
        cyc();
        check("ar_lat3_v", dn.valid, 1);
        check("ar_lat3_d", dn.data, 8'h7E);
        cyc();
        exp_q = '{8'h7E};
        check_got("ar_order");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
